// File: rtl/bsg_fsb_link_serdes.sv
// bsg_fsb_link_serdes: narrow-link adapter on the FSB side of the tunnel.
// TX slices FSB packets into chunks; RX reassembles chunks into packets.
//
// Ports:
//   clk_i, reset_n_i        clock, asynchronous active-low reset
//   fsb_v_i/fsb_data_i      TX packet in (held stable while valid)
//   fsb_yumi_o              TX packet consumed (with its last chunk)
//   tx_v_o/tx_data_o        TX chunk out, tx_last_o marks final chunk
//   tx_ready_i              link accepts the current chunk
//   rx_v_i/rx_data_i        RX chunk in, rx_last_i is sender's marker
//   rx_ready_o              chunk taken when rx_v_i & rx_ready_o
//   fsb_v_o/fsb_data_o      reassembled packet out
//   fsb_ready_i             downstream accepts the packet
//   frame_err_o             sticky RX framing error
module bsg_fsb_link_serdes #(
    parameter int ring_width_p = 80,
    parameter int chan_width_p = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,

    input  logic                    fsb_v_i,
    input  logic [ring_width_p-1:0] fsb_data_i,
    output logic                    fsb_yumi_o,

    output logic                    tx_v_o,
    output logic [chan_width_p-1:0] tx_data_o,
    output logic                    tx_last_o,
    input  logic                    tx_ready_i,

    input  logic                    rx_v_i,
    input  logic [chan_width_p-1:0] rx_data_i,
    input  logic                    rx_last_i,
    output logic                    rx_ready_o,

    output logic                    fsb_v_o,
    output logic [ring_width_p-1:0] fsb_data_o,
    input  logic                    fsb_ready_i,

    output logic                    frame_err_o
);

    localparam int num_chunks_lp =
        (ring_width_p + chan_width_p - 1) / chan_width_p;
    localparam int pad_width_lp = num_chunks_lp * chan_width_p;
    localparam int cnt_width_lp =
        (num_chunks_lp > 1) ? $clog2(num_chunks_lp) : 1;
    localparam logic [cnt_width_lp-1:0] last_cnt_lp =
        cnt_width_lp'(num_chunks_lp - 1);
    localparam logic [cnt_width_lp-1:0] one_lp = cnt_width_lp'(1);

    logic [cnt_width_lp-1:0] tx_cnt_q, tx_cnt_d;
    logic [cnt_width_lp-1:0] rx_cnt_q, rx_cnt_d;
    logic                    full_q, full_d;
    logic                    err_q, err_d;
    logic [pad_width_lp-1:0] asm_q, asm_d;

    logic [pad_width_lp-1:0] tx_pad;
    logic                    tx_fire;
    logic                    rx_fire;
    logic                    rx_at_end;
    logic                    rx_err;
    logic                    rx_done;
    logic                    unused_asm;

    // ---------------- TX ----------------
    always_comb begin
        // Zero-extend so the final chunk pads with zeros.
        tx_pad = '0;
        tx_pad[ring_width_p-1:0] = fsb_data_i;

        tx_data_o = '0;
        for (int i = 0; i < num_chunks_lp; i++) begin
            if (tx_cnt_q == cnt_width_lp'(i)) begin
                tx_data_o = tx_pad[i*chan_width_p +: chan_width_p];
            end
        end

        tx_v_o     = fsb_v_i;
        tx_last_o  = (tx_cnt_q == last_cnt_lp);
        tx_fire    = fsb_v_i & tx_ready_i;
        fsb_yumi_o = tx_fire & tx_last_o;

        // Counter only moves on a handshake, so a dropped
        // fsb_v_i mid-packet simply holds the position.
        tx_cnt_d = tx_cnt_q;
        if (tx_fire) begin
            tx_cnt_d = tx_last_o ? '0 : tx_cnt_q + one_lp;
        end
    end

    // ---------------- RX ----------------
    always_comb begin
        rx_ready_o = ~full_q | fsb_ready_i;
        rx_fire    = rx_v_i & rx_ready_o;
        rx_at_end  = (rx_cnt_q == last_cnt_lp);

        // Marker must appear exactly on the final slot.
        rx_err  = rx_fire & (rx_last_i ^ rx_at_end);
        rx_done = rx_fire & rx_last_i & rx_at_end;

        rx_cnt_d = rx_cnt_q;
        if (rx_fire) begin
            if (rx_at_end | rx_last_i) begin
                rx_cnt_d = '0;
            end else begin
                rx_cnt_d = rx_cnt_q + one_lp;
            end
        end

        // A bad chunk is discarded; the partial packet is
        // abandoned and overwritten by the next one.
        asm_d = asm_q;
        if (rx_fire & ~rx_err) begin
            for (int i = 0; i < num_chunks_lp; i++) begin
                if (rx_cnt_q == cnt_width_lp'(i)) begin
                    asm_d[i*chan_width_p +: chan_width_p] = rx_data_i;
                end
            end
        end

        // Completion wins over dequeue in the same cycle.
        full_d = full_q;
        if (rx_done) begin
            full_d = 1'b1;
        end else if (full_q & fsb_ready_i) begin
            full_d = 1'b0;
        end

        err_d = err_q | rx_err;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
            full_q   <= 1'b0;
            err_q    <= 1'b0;
            asm_q    <= '0;
        end else begin
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            full_q   <= full_d;
            err_q    <= err_d;
            asm_q    <= asm_d;
        end
    end

    assign fsb_v_o     = full_q;
    assign fsb_data_o  = asm_q[ring_width_p-1:0];
    assign frame_err_o = err_q;

    // Pad bits above ring_width_p are never presented.
    assign unused_asm = ^asm_q;

endmodule
